// File: rtl/gate_arb_pkg.sv
// Shared types and constants for the gate_unit_arbiter block.
// Optional per-requester op counters are enabled with GATE_ARB_STATS_EN.
package gate_arb_pkg;

   localparam int unsigned STAT_W = 16;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_NAND = 2'b11
   } gate_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      DONE = 2'b10
   } arb_state_t;

endpackage

// File: rtl/logic_gate_unit.sv
// Shared combinational bitwise gate datapath: AND / OR / XOR / NAND over W bits.
module logic_gate_unit
   import gate_arb_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  gate_op_t     op,
   output logic [W-1:0] y
);

   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one logic_gate_unit among N requesters.
// Define GATE_ARB_STATS_EN to add per-requester completed-op counters (op_count).
module gate_unit_arbiter
   import gate_arb_pkg::*;
#(
   parameter int unsigned N   = 4,
   parameter int unsigned W   = 8,
   parameter int unsigned IDW = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic [2*N-1:0]   op,
   input  logic [W*N-1:0]   a,
   input  logic [W*N-1:0]   b,
   output logic [N-1:0]     gnt,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [W-1:0]     res,
   output logic [IDW-1:0]   res_id
`ifdef GATE_ARB_STATS_EN
   ,
   output logic [N*STAT_W-1:0] op_count
`endif
);

   localparam int unsigned IDW1 = IDW + 1;
   localparam logic [IDW:0] N_W  = IDW1'(N);

   arb_state_t       state;
   arb_state_t       state_d;
   logic [IDW-1:0]   rr_ptr;
   logic [N-1:0]     rot_req;
   logic             found;
   logic [IDW-1:0]   sel_off;
   logic [IDW:0]     sel_sum;
   logic [IDW-1:0]   sel;
   logic [IDW:0]     ptr_sum;
   logic [IDW-1:0]   ptr_nxt;
   logic [1:0]       op_sel;
   logic [W-1:0]     a_sel;
   logic [W-1:0]     b_sel;
   gate_op_t         op_q;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic [IDW-1:0]   id_q;
   logic [W-1:0]     y;
   logic             grant_c;
   logic             exec_c;
   logic             accept_c;

   // Rotate requests so bit 0 is the requester at rr_ptr, then take the lowest set bit.
   assign rot_req = N'({req, req} >> rr_ptr);

   always_comb begin
      found   = 1'b0;
      sel_off = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && rot_req[i]) begin
            found   = 1'b1;
            sel_off = IDW'(i);
         end
      end
   end

   // Map the rotated offset back to a requester index; wraps at N, not 2^IDW.
   always_comb begin
      sel_sum = {1'b0, rr_ptr} + {1'b0, sel_off};
      sel     = (sel_sum >= N_W) ? IDW'(sel_sum - N_W) : IDW'(sel_sum);
      ptr_sum = {1'b0, sel} + IDW1'(1);
      ptr_nxt = (ptr_sum >= N_W) ? '0 : IDW'(ptr_sum);
   end

   // Operand mux for the selected requester.
   always_comb begin
      op_sel = '0;
      a_sel  = '0;
      b_sel  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (sel == IDW'(i)) begin
            op_sel = op[2*i +: 2];
            a_sel  = a[W*i +: W];
            b_sel  = b[W*i +: W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   // Next state and control strobes; gnt is held low while reset is asserted.
   always_comb begin
      state_d  = state;
      gnt      = '0;
      grant_c  = 1'b0;
      exec_c   = 1'b0;
      accept_c = 1'b0;
      case (state)
         IDLE: begin
            if (found && rst_n) begin
               gnt     = N'(1) << sel;
               grant_c = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            exec_c  = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            if (res_valid && res_ready) begin
               accept_c = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand capture, result register and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         op_q      <= OP_AND;
         a_q       <= '0;
         b_q       <= '0;
         id_q      <= '0;
         res       <= '0;
         res_id    <= '0;
         res_valid <= 1'b0;
      end else begin
         if (grant_c) begin
            op_q   <= gate_op_t'(op_sel);
            a_q    <= a_sel;
            b_q    <= b_sel;
            id_q   <= sel;
            rr_ptr <= ptr_nxt;
         end
         if (exec_c) begin
            res       <= y;
            res_id    <= id_q;
            res_valid <= 1'b1;
         end
         if (accept_c) begin
            res_valid <= 1'b0;
         end
      end
   end

   logic_gate_unit #(.W(W)) u_gate (
      .a  (a_q),
      .b  (b_q),
      .op (op_q),
      .y  (y)
   );

`ifdef GATE_ARB_STATS_EN
   // Completed-handshake counters per requester, wrapping at 2^STAT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (accept_c) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (res_id == IDW'(i)) begin
               op_count[STAT_W*i +: STAT_W] <= op_count[STAT_W*i +: STAT_W] + STAT_W'(1);
            end
         end
      end
   end
`endif

endmodule
